// File: rtl/st_align_unit.sv
// Store alignment unit: turns a core store request into one or two word-aligned
// memory write beats with lane-shifted data and byte strobes.
module st_align_unit #(
    parameter int unsigned ALLOW_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [3:0]  wstrb_q, wstrb_nxt;
    logic [31:0] hi_wdata_q, hi_wdata_nxt;
    logic [3:0]  hi_wstrb_q, hi_wstrb_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;

    logic        legal;
    logic [3:0]  size_mask;
    logic [31:0] data_mask;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic        crosses;
    logic        reject;

    always_comb begin
        legal     = 1'b1;
        size_mask = '0;
        data_mask = '0;
        case (req_func3)
            3'b000: begin size_mask = 4'b0001; data_mask = 32'h0000_00FF; end
            3'b001: begin size_mask = 4'b0011; data_mask = 32'h0000_FFFF; end
            3'b010: begin size_mask = 4'b1111; data_mask = 32'hFFFF_FFFF; end
            default: legal = 1'b0;
        endcase
        // Upper half of the 8-lane window belongs to the following word.
        mask8   = {4'b0000, size_mask} << req_addr[1:0];
        data64  = {32'h0000_0000, req_data & data_mask} << {req_addr[1:0], 3'b000};
        crosses = |mask8[7:4];
        reject  = !legal || (crosses && (ALLOW_MISALIGN == 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            hi_wdata_q <= '0;
            hi_wstrb_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            wstrb_q    <= wstrb_nxt;
            hi_wdata_q <= hi_wdata_nxt;
            hi_wstrb_q <= hi_wstrb_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        wstrb_nxt    = wstrb_q;
        hi_wdata_nxt = hi_wdata_q;
        hi_wstrb_nxt = hi_wstrb_q;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt    = BEAT0;
                        addr_nxt     = {req_addr[31:2], 2'b00};
                        wdata_nxt    = data64[31:0];
                        wstrb_nxt    = mask8[3:0];
                        hi_wdata_nxt = data64[63:32];
                        hi_wstrb_nxt = mask8[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (hi_wstrb_q == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        addr_nxt  = '0;
                        wdata_nxt = '0;
                        wstrb_nxt = '0;
                    end else begin
                        state_nxt = BEAT1;
                        addr_nxt  = addr_q + 32'd4;
                        wdata_nxt = hi_wdata_q;
                        wstrb_nxt = hi_wstrb_q;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    addr_nxt  = '0;
                    wdata_nxt = '0;
                    wstrb_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign mem_valid = (state == BEAT0) || (state == BEAT1);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_st_align_unit.sv
// Bench for st_align_unit: byte-level reference model with a per-cycle compare,
// directed cases with literal expectations, then randomized traffic.
module tb_st_align_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        mem_ready = 1'b0;

    logic        req_ready, mem_valid, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        ready0, mem_valid0, busy0, done0, err0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  wstrb0;

    st_align_unit #(.ALLOW_MISALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_func3(req_func3), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy), .done(done), .err(err)
    );

    st_align_unit #(.ALLOW_MISALIGN(0)) dut_strict (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
        .req_func3(req_func3), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_wstrb(wstrb0), .busy(busy0), .done(done0), .err(err0)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total  = 0;
    beat_t exp_q[$];
    beat_t seen_q[$];
    logic  exp_done = 1'b0;
    logic  exp_err  = 1'b0;
    int    ready_mode = 0;
    int    stall_len  = 3;
    int    stall_cnt  = 0;
    logic  err0_k1, mv0_k1, ready0_k1, err0_k2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: place each stored byte individually by its own byte address.
    function automatic void build(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                  output bit ok, output int nb, output beat_t b0, output beat_t b1);
        logic [31:0] base, ba;
        int n;
        ok = (f3 <= 3'd2);
        n = 1 << f3;
        base = {a[31:2], 2'b00};
        b0 = '{addr: base, wdata: 32'h0, strb: 4'h0};
        b1 = '{addr: base + 32'd4, wdata: 32'h0, strb: 4'h0};
        nb = 1;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                if ({ba[31:2], 2'b00} == base) begin
                    b0.wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
                    b0.strb[ba[1:0]] = 1'b1;
                end else begin
                    b1.wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
                    b1.strb[ba[1:0]] = 1'b1;
                    nb = 2;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        bit ok;
        int nb;
        beat_t b0, b1;
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 1'b0;
            exp_err  = 1'b0;
        end else begin
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("req_ready", req_ready, exp_q.size() == 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("mem_valid", mem_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("mem_addr", mem_addr, exp_q[0].addr);
                chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                chk("mem_wstrb", mem_wstrb, exp_q[0].strb);
            end
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (exp_q.size() == 0) begin
                if (req_valid) begin
                    build(req_func3, req_addr, req_data, ok, nb, b0, b1);
                    if (!ok) exp_err = 1'b1;
                    else begin
                        exp_q.push_back(b0);
                        if (nb == 2) exp_q.push_back(b1);
                    end
                end
            end else if (mem_ready) begin
                seen_q.push_back(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end
    end

    always begin
        logic hs;
        @(posedge clk);
        hs = mem_valid && mem_ready;
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (hs || !mem_valid) stall_cnt = 0;
                if (mem_valid) begin
                    mem_ready = (stall_cnt >= stall_len);
                    stall_cnt++;
                end else mem_ready = 1'b0;
            end
        endcase
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit got;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_func3 = f3; req_addr = a; req_data = d;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic was_err);
        issue(f3, a, d);
        lat = -1;
        was_err = 1'b0;
        for (int k = 1; k <= 50 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin err0_k1 = err0; mv0_k1 = mem_valid0; ready0_k1 = ready0; end
            if (k == 2) err0_k2 = err0;
            if (done || err) begin lat = k; was_err = err; end
        end
        if (lat < 0) chk("completion_timeout", 0, 1);
    endtask

    task automatic chk_seen(input string name, input int idx, input beat_t b);
        if (seen_q.size() > idx) chk(name, seen_q[idx], b);
        else chk({name, "_missing"}, seen_q.size(), idx + 1);
    endtask

    initial begin
        int lat;
        logic e;
        bit ok;
        int nb;
        beat_t b0, b1;

        build(3'b001, 32'h203, 32'hBEEF, ok, nb, b0, b1);
        chk("model_sh_nb", nb, 2);
        chk("model_sh_b0", b0, {32'h200, 32'hEF00_0000, 4'b1000});
        chk("model_sh_b1", b1, {32'h204, 32'h0000_00BE, 4'b0001});
        build(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, ok, nb, b0, b1);
        chk("model_wrap_b1", b1, {32'h0, 32'h0000_AABB, 4'b0011});

        #12;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_done_err_busy", {done, err, busy}, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        ready_mode = 0;
        seen_q.delete();
        do_store(3'b010, 32'h100, 32'h1234_5678, lat, e);
        chk("sw_latency", lat, 2);
        chk("sw_beat", seen_q[0], {32'h100, 32'h1234_5678, 4'b1111});

        seen_q.delete();
        do_store(3'b000, 32'h103, 32'hFFFF_FFAB, lat, e);
        chk("sb_latency", lat, 2);
        chk_seen("sb_beat", 0, {32'h100, 32'hAB00_0000, 4'b1000});

        seen_q.delete();
        do_store(3'b001, 32'h203, 32'h0000_BEEF, lat, e);
        chk("sh_split_latency", lat, 3);
        chk_seen("sh_beat0", 0, {32'h200, 32'hEF00_0000, 4'b1000});
        chk_seen("sh_beat1", 1, {32'h204, 32'h0000_00BE, 4'b0001});
        chk("strict_err_t1", err0_k1, 1);
        chk("strict_no_beat", mv0_k1, 0);
        chk("strict_ready", ready0_k1, 1);
        chk("strict_err_pulse", err0_k2, 0);

        seen_q.delete();
        do_store(3'b100, 32'h300, 32'h1111_2222, lat, e);
        chk("illegal_err", e, 1);
        chk("illegal_latency", lat, 1);
        chk("illegal_no_beat", seen_q.size(), 0);

        ready_mode = 2;
        stall_len = 3;
        seen_q.delete();
        do_store(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, lat, e);
        chk("wrap_latency", lat, 9);
        chk_seen("wrap_beat0", 0, {32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100});
        chk_seen("wrap_beat1", 1, {32'h0, 32'h0000_AABB, 4'b0011});

        seen_q.delete();
        issue(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD);
        for (int k = 0; k < 30 && seen_q.size() < 1; k++) @(negedge clk);
        chk("abort_reached_beat1", seen_q.size(), 1);
        @(posedge clk);
        #1;
        chk("abort_in_beat1", {mem_valid, mem_addr}, {1'b1, 32'h0});
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_valid", mem_valid, 0);
        chk("abort_flags", {busy, done, err, req_ready}, 4'b0001);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        ready_mode = 0;
        seen_q.delete();
        do_store(3'b010, 32'h40, 32'hCAFE_F00D, lat, e);
        chk("after_reset_latency", lat, 2);
        chk_seen("after_reset_beat", 0, {32'h40, 32'hCAFE_F00D, 4'b1111});

        ready_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk);
            #1;
            r = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 2) != 0);
            req_func3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            req_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                    : $urandom;
            req_data  = $urandom;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        ready_mode = 0;
        begin
            bit idle = 0;
            for (int k = 0; k < 50 && !idle; k++) begin
                @(negedge clk);
                if (req_ready) idle = 1;
            end
            chk("drain_idle", idle, 1);
        end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
